uart_rx_frame_receiver: RTL and testbench
=========================================

# uart_rx_frame_receiver

- Receive-side counterpart of the UART TX path.
- Oversamples the serial line, detects the start bit, deserializes DATA_WIDTH bits LSB-first, then checks the optional parity bit and the stop bit.
- Delivers a parallel word with a one-cycle valid strobe, or reports a parity/stop error.
- Sits between the RX pin synchronizer and the system register/FIFO layer, and uses the same parity convention as the TX parity calculator.

## Interface
Parameters:
- DATA_WIDTH, 8, data bits per frame.
- PRESCALE, 8, clk cycles per bit. Must be even and ≥ 4.

Ports:
- clk  input  1  system clock. Reset is synchronous and active-high.
- rst  input  1  synchronous, active-high reset.
- RX_IN  input  1  serial line, already synchronized. Idles high.
- PAR_EN  input  1  1 = a parity bit follows the data.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity.
- P_DATA  output  DATA_WIDTH  last correctly received word.
- data_valid  output  1  one-cycle pulse when P_DATA is updated.
- par_err  output  1  one-cycle pulse at frame end on parity mismatch.
- stp_err  output  1  one-cycle pulse at frame end when the stop bit is sampled 0.

## Operation
State machine:
- States: IDLE → START → DATA → PARITY → STOP → IDLE.
- PARITY is skipped when the latched PAR_EN = 0.

Counters:
- edge_cnt runs 0..PRESCALE-1 within each bit.
- bit_cnt runs 0..DATA_WIDTH-1 in DATA.

IDLE:
- When RX_IN = 0, that cycle is edge 0 of the start bit.
- Next state is START with edge_cnt = 1.
- PAR_EN and PAR_TYP are latched in the same cycle. Changes to them mid-frame are ignored.

Bit sampling:
- RX_IN is sampled at edge_cnt = PRESCALE/2-1, PRESCALE/2 and PRESCALE/2+1.
- The bit value is the majority of the 3 samples.
- The value is resolved at edge_cnt = PRESCALE-1.

START:
- If the start bit resolves to 1 (glitch), return to IDLE. No outputs are produced.

DATA:
- Resolved bits shift in LSB-first.
- After bit DATA_WIDTH-1, go to PARITY, or to STOP when parity is disabled.

PARITY:
- Expected bit is ^data for even parity and ~^data for odd parity.
- A mismatch sets an internal error flag.

STOP, at edge_cnt = PRESCALE-1 (frame end), the outputs registered for the next cycle are:
- If stop = 1 and no parity error: P_DATA ← shift register and data_valid = 1.
- If there is a parity error: par_err = 1. P_DATA is unchanged.
- If stop = 0: stp_err = 1. P_DATA is unchanged.
- par_err and stp_err may pulse together. data_valid is never asserted together with either error.
- The state moves to IDLE on that same edge.

## Timing
- Frame length N = DATA_WIDTH + 2 + PAR_EN bits, i.e. N·PRESCALE cycles.
- The falling edge is seen in cycle 0. data_valid, par_err and stp_err are high in cycle N·PRESCALE, for exactly one cycle.
- Back-to-back frames: a start bit low in cycle N·PRESCALE is detected, because the FSM is already in IDLE. No dead cycle.

Reset values:
- State = IDLE.
- All counters and the shift register = 0.
- P_DATA = 0; data_valid, par_err and stp_err = 0.

Reset during a frame:
- The frame is aborted and no strobe is produced for it.
- Reception resumes on the first low RX_IN after rst deasserts.

Other rules:
- RX_IN is ignored outside the sample points, except in IDLE.
- Frame errors never stall the block.

## Structure
Shared package/include uart_pkg holds:
- The state encoding (IDLE, START, DATA, PARITY, STOP).
- Parity constants PAR_EVEN = 0 and PAR_ODD = 1, shared with the TX side.

Sub-module uart_rx_sampler contains:
- The edge counter.
- The 3-sample majority voter.
- Outputs bit_val and bit_done (edge_cnt = PRESCALE-1).

The FSM, shift register and checks live in the top module.

## Test plan
All scenarios use PRESCALE = 8 and DATA_WIDTH = 8.
- Even-parity frame 0xA5 (parity bit 0, stop bit 1) → data_valid in cycle 88, P_DATA = 0xA5, par_err = 0, stp_err = 0.
- Same frame with parity bit 1 → par_err pulse in cycle 88, no data_valid, P_DATA keeps its previous value.
- PAR_EN = 0, frame 0x3C with stop bit 0 → stp_err pulse in cycle 80, no data_valid.
- RX_IN low only in cycles 0–2, then high → start bit resolves to 1, back to IDLE, no strobes. A following valid frame 0x5A is received correctly.
- Odd-parity frame 0x01 (parity bit 0) immediately followed by 0xFF (parity bit 1) → data_valid pulses in cycles 88 and 176 with P_DATA = 0x01, then 0xFF.
- rst asserted in cycle 40 of a frame → all outputs 0, no strobe for that frame. The next frame, 0x77, is received with data_valid.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the parity convention used by TX and RX.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter and 3-sample majority voter around the bit centre.
module uart_rx_sampler #(
  parameter int unsigned PRESCALE = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic active,
  input  logic rx,
  output logic bit_val,
  output logic bit_done
);

  localparam int unsigned EDGE_W = $clog2(PRESCALE);
  localparam logic [EDGE_W-1:0] SMP_LO  = EDGE_W'(PRESCALE / 2 - 1);
  localparam logic [EDGE_W-1:0] SMP_MID = EDGE_W'(PRESCALE / 2);
  localparam logic [EDGE_W-1:0] SMP_HI  = EDGE_W'(PRESCALE / 2 + 1);
  localparam logic [EDGE_W-1:0] LAST    = EDGE_W'(PRESCALE - 1);

  logic [EDGE_W-1:0] edge_cnt;
  logic [2:0]        samples;
  logic              smp_hi_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      edge_cnt <= '0;
      samples  <= '0;
    end else begin
      // the falling edge itself is edge 0, so the next cycle is edge 1
      if (start) begin
        edge_cnt <= EDGE_W'(1);
      end else if (active) begin
        edge_cnt <= (edge_cnt == LAST) ? '0 : edge_cnt + EDGE_W'(1);
      end else begin
        edge_cnt <= '0;
      end
      if (active) begin
        if (edge_cnt == SMP_LO)  samples[0] <= rx;
        if (edge_cnt == SMP_MID) samples[1] <= rx;
        if (edge_cnt == SMP_HI)  samples[2] <= rx;
      end
    end
  end

  // With PRESCALE = 4 the last sample point coincides with the resolve edge
  assign smp_hi_c = (edge_cnt == SMP_HI) ? rx : samples[2];
  assign bit_val  = (samples[0] & samples[1]) | (samples[0] & smp_hi_c) | (samples[1] & smp_hi_c);
  assign bit_done = active && (edge_cnt == LAST);

endmodule

// File: rtl/uart_rx_frame_receiver.sv
// UART receive frame FSM: start detect, LSB-first deserialize, optional parity and stop check.
module uart_rx_frame_receiver #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESCALE   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);
  import uart_pkg::*;

  localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  rx_state_t             state, state_n;
  logic [CNT_W-1:0]      bit_cnt, bit_cnt_n;
  logic [DATA_WIDTH-1:0] shift, shift_n;
  logic [DATA_WIDTH-1:0] p_data_n;
  logic                  par_en_q, par_en_n;
  logic                  par_typ_q, par_typ_n;
  logic                  par_bad, par_bad_n;
  logic                  data_valid_n, par_err_n, stp_err_n;
  logic                  start_c, active_c, exp_par_c;
  logic                  bit_val, bit_done;

  assign start_c   = (state == IDLE) && !RX_IN;
  assign active_c  = (state != IDLE);
  assign exp_par_c = (par_typ_q == PAR_ODD) ? ~^shift : ^shift;

  uart_rx_sampler #(.PRESCALE(PRESCALE)) u_sampler (
    .clk      (clk),
    .rst      (rst),
    .start    (start_c),
    .active   (active_c),
    .rx       (RX_IN),
    .bit_val  (bit_val),
    .bit_done (bit_done)
  );

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      par_bad    <= 1'b0;
      P_DATA     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      shift      <= shift_n;
      par_en_q   <= par_en_n;
      par_typ_q  <= par_typ_n;
      par_bad    <= par_bad_n;
      P_DATA     <= p_data_n;
      data_valid <= data_valid_n;
      par_err    <= par_err_n;
      stp_err    <= stp_err_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n      = state;
    bit_cnt_n    = bit_cnt;
    shift_n      = shift;
    par_en_n     = par_en_q;
    par_typ_n    = par_typ_q;
    par_bad_n    = par_bad;
    p_data_n     = P_DATA;
    data_valid_n = 1'b0;
    par_err_n    = 1'b0;
    stp_err_n    = 1'b0;

    unique case (state)
      IDLE: begin
        if (!RX_IN) begin
          state_n   = START;
          par_en_n  = PAR_EN;
          par_typ_n = PAR_TYP;
          par_bad_n = 1'b0;
          bit_cnt_n = '0;
        end
      end
      START: begin
        if (bit_done) begin
          state_n   = bit_val ? IDLE : DATA;
          bit_cnt_n = '0;
        end
      end
      DATA: begin
        if (bit_done) begin
          shift_n = {bit_val, shift[DATA_WIDTH-1:1]};
          if (bit_cnt == LAST_BIT) begin
            state_n = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_n = bit_cnt + CNT_W'(1);
          end
        end
      end
      PARITY: begin
        if (bit_done) begin
          par_bad_n = (bit_val != exp_par_c);
          state_n   = STOP;
        end
      end
      STOP: begin
        if (bit_done) begin
          state_n   = IDLE;
          par_err_n = par_bad;
          stp_err_n = !bit_val;
          if (bit_val && !par_bad) begin
            p_data_n     = shift;
            data_valid_n = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_frame_receiver.sv
// Waveform-level bench: builds a cycle-indexed line image, decodes it with a behavioural model, compares every cycle.
module tb_uart_rx_frame_receiver;
  import uart_pkg::*;

  localparam int W    = 8;
  localparam int P    = 8;
  localparam int MAXC = 8192;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rx_in = 1'b1;
  logic         par_en = 1'b0;
  logic         par_typ = 1'b0;
  logic [W-1:0] p_data;
  logic         data_valid, par_err, stp_err;

  always #5 clk = ~clk;

  uart_rx_frame_receiver #(.DATA_WIDTH(W), .PRESCALE(P)) dut (
    .clk        (clk),
    .rst        (rst),
    .RX_IN      (rx_in),
    .PAR_EN     (par_en),
    .PAR_TYP    (par_typ),
    .P_DATA     (p_data),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stp_err    (stp_err)
  );

  logic         w_rx  [MAXC];
  logic         w_rst [MAXC];
  logic         w_pe  [MAXC];
  logic         w_pt  [MAXC];
  logic         e_dv  [MAXC];
  logic         e_pe  [MAXC];
  logic         e_se  [MAXC];
  logic [W-1:0] e_pd  [MAXC];
  logic         u_v   [MAXC];
  logic [W-1:0] u_d   [MAXC];

  typedef struct {
    int           cyc;
    logic         dv;
    logic         pe;
    logic         se;
    logic [W-1:0] pd;
  } lit_t;
  lit_t lits[$];

  int cur;
  int cyc;
  bit run = 1'b0;
  int checks = 0;
  int errors = 0;

  task automatic put_bit(input logic b, input logic noisy);
    logic v;
    for (int e = 0; e < P; e++) begin
      v = b;
      if (noisy && e != 0 && (e < P/2-1 || e > P/2+1) && $urandom_range(0, 2) == 0) v = ~b;
      if (noisy && e == P/2 && $urandom_range(0, 5) == 0) v = ~b;
      w_rx[cur] = v;
      cur++;
    end
  endtask

  task automatic put_frame(input logic [W-1:0] d, input logic pe, input logic pt,
                           input logic bad_par, input logic stop, input logic noisy);
    w_pe[cur] = pe;
    w_pt[cur] = pt;
    put_bit(1'b0, noisy);
    for (int i = 0; i < W; i++) put_bit(d[i], noisy);
    if (pe) put_bit((^d) ^ pt ^ bad_par, noisy);
    put_bit(stop, noisy);
  endtask

  function automatic void lit(input int c, input logic dv, input logic pe, input logic se,
                              input logic [W-1:0] pd);
    lit_t l;
    l.cyc = c; l.dv = dv; l.pe = pe; l.se = se; l.pd = pd;
    lits.push_back(l);
  endfunction

  function automatic logic maj(input int s, input int k);
    int b;
    int n;
    b = s + k*P + P/2 - 1;
    n = int'(w_rx[b]) + int'(w_rx[b+1]) + int'(w_rx[b+2]);
    return n >= 2;
  endfunction

  // Decode the line image frame by frame into per-cycle expected outputs
  task automatic build_model();
    int t, s, n, e, lim, r;
    logic b0, stop, perr, pe, pt;
    logic [W-1:0] d, pd;
    for (int c = 0; c < MAXC; c++) begin
      e_dv[c] = 1'b0; e_pe[c] = 1'b0; e_se[c] = 1'b0; u_v[c] = 1'b0; u_d[c] = '0;
    end
    t = 0;
    while (t < MAXC) begin
      if (w_rst[t]) begin
        if (t + 1 < MAXC) begin u_v[t+1] = 1'b1; u_d[t+1] = '0; end
        t++;
        continue;
      end
      if (w_rx[t]) begin t++; continue; end
      s  = t;
      pe = w_pe[s];
      pt = w_pt[s];
      n  = W + 2 + int'(pe);
      e  = s + n*P;
      if (e >= MAXC) break;
      b0  = maj(s, 0);
      lim = b0 ? s + P : e;
      r   = -1;
      for (int i = s + 1; i < lim; i++) if (w_rst[i] && r < 0) r = i;
      if (r >= 0) begin t = r; continue; end
      if (b0) begin t = s + P; continue; end
      for (int k = 0; k < W; k++) d[k] = maj(s, k + 1);
      perr = 1'b0;
      if (pe) perr = (maj(s, W + 1) != ((^d) ^ pt));
      stop = maj(s, n - 1);
      e_dv[e] = stop && !perr;
      e_pe[e] = perr;
      e_se[e] = !stop;
      if (stop && !perr) begin u_v[e] = 1'b1; u_d[e] = d; end
      t = e;
    end
    pd = '0;
    for (int c = 0; c < MAXC; c++) begin
      if (u_v[c]) pd = u_d[c];
      e_pd[c] = pd;
    end
  endtask

  task automatic chk(input string nm, input int c, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, c, got, exp);
    end
  endtask

  // Per-cycle compare against the model plus the pinned literal points
  always @(negedge clk) begin
    if (run && cyc >= 1) begin
      chk("data_valid", cyc, W'(data_valid), W'(e_dv[cyc]));
      chk("par_err",    cyc, W'(par_err),    W'(e_pe[cyc]));
      chk("stp_err",    cyc, W'(stp_err),    W'(e_se[cyc]));
      chk("p_data",     cyc, p_data,         e_pd[cyc]);
      foreach (lits[i]) begin
        if (lits[i].cyc == cyc) begin
          chk("lit_data_valid", cyc, W'(data_valid), W'(lits[i].dv));
          chk("lit_par_err",    cyc, W'(par_err),    W'(lits[i].pe));
          chk("lit_stp_err",    cyc, W'(stp_err),    W'(lits[i].se));
          chk("lit_p_data",     cyc, p_data,         lits[i].pd);
        end
      end
    end
  end

  initial begin
    int s, len, kind;
    logic [W-1:0] d;
    logic pe;
    for (int c = 0; c < MAXC; c++) begin
      w_rx[c] = 1'b1; w_rst[c] = 1'b0; w_pe[c] = 1'($urandom); w_pt[c] = 1'($urandom);
    end
    for (int c = 0; c < 4; c++) w_rst[c] = 1'b1;
    lit(1, 1'b0, 1'b0, 1'b0, 8'h00);
    cur = 10;

    s = cur; put_frame(8'hA5, 1'b1, PAR_EVEN, 1'b0, 1'b1, 1'b0);
    lit(s + 88, 1'b1, 1'b0, 1'b0, 8'hA5);
    cur += 5;
    s = cur; put_frame(8'hA5, 1'b1, PAR_EVEN, 1'b1, 1'b1, 1'b0);
    lit(s + 88, 1'b0, 1'b1, 1'b0, 8'hA5);
    cur += 5;
    s = cur; put_frame(8'h3C, 1'b0, PAR_EVEN, 1'b0, 1'b0, 1'b0);
    lit(s + 80, 1'b0, 1'b0, 1'b1, 8'hA5);
    cur += 5;
    s = cur;
    for (int i = 0; i < 3; i++) w_rx[s + i] = 1'b0;
    lit(s + 8, 1'b0, 1'b0, 1'b0, 8'hA5);
    cur += 20;
    s = cur; put_frame(8'h5A, 1'b0, PAR_EVEN, 1'b0, 1'b1, 1'b0);
    lit(s + 80, 1'b1, 1'b0, 1'b0, 8'h5A);
    cur += 3;
    s = cur;
    put_frame(8'h01, 1'b1, PAR_ODD, 1'b0, 1'b1, 1'b0);
    put_frame(8'hFF, 1'b1, PAR_ODD, 1'b0, 1'b1, 1'b0);
    lit(s + 88,  1'b1, 1'b0, 1'b0, 8'h01);
    lit(s + 89,  1'b0, 1'b0, 1'b0, 8'h01);
    lit(s + 176, 1'b1, 1'b0, 1'b0, 8'hFF);
    cur += 4;
    s = cur; put_frame(8'h12, 1'b0, PAR_EVEN, 1'b0, 1'b1, 1'b0);
    w_rst[s + 40] = 1'b1;
    for (int i = s + 41; i < s + 80; i++) w_rx[i] = 1'b1;
    lit(s + 41, 1'b0, 1'b0, 1'b0, 8'h00);
    lit(s + 80, 1'b0, 1'b0, 1'b0, 8'h00);
    cur += 6;
    s = cur; put_frame(8'h77, 1'b1, PAR_EVEN, 1'b0, 1'b1, 1'b0);
    lit(s + 88, 1'b1, 1'b0, 1'b0, 8'h77);
    cur += 7;

    while (cur < MAXC - 300) begin
      kind = $urandom_range(0, 19);
      if (kind == 0) begin
        len = $urandom_range(1, 4);
        for (int i = 0; i < len; i++) w_rx[cur + i] = 1'b0;
        cur += P + $urandom_range(1, 6);
      end else begin
        d  = W'($urandom);
        pe = 1'($urandom);
        s  = cur;
        put_frame(d, pe, 1'($urandom), $urandom_range(0, 4) == 0, $urandom_range(0, 5) != 0, 1'($urandom));
        if (kind == 1) w_rst[s + $urandom_range(1, (W + 2 + int'(pe))*P - 1)] = 1'b1;
        cur += $urandom_range(0, 6);
      end
    end

    build_model();

    run = 1'b1;
    for (int c = 0; c < MAXC; c++) begin
      @(posedge clk);
      #1;
      cyc     = c;
      rst     = w_rst[c];
      rx_in   = w_rx[c];
      par_en  = w_pe[c];
      par_typ = w_pt[c];
    end
    @(posedge clk);
    #1;
    run = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
